// File: rtl/convolver_window_ctrl.sv
// Sequencing controller for the convolver input shift chain: accepts a raster pixel
// stream, drives the chain shift strobe/data and flags cycles holding a full window.
module convolver_window_ctrl #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int KERNEL     = 3,
  parameter int STRIDE     = 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  shift_en,
  output logic [DATA_WIDTH-1:0] shift_data,
  output logic                  window_valid,
  output logic [15:0]           window_count,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int PW = (STRIDE     > 1) ? $clog2(STRIDE)     : 1;

  logic [1:0]    state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [PW-1:0] col_phase;
  logic [PW-1:0] row_phase;
  logic          accept;
  logic          col_last;
  logic          row_last;
  logic          col_in;
  logic          row_in;
  logic          qualify;

  assign in_ready   = (state == RUN);
  assign busy       = (state == RUN);
  assign done       = (state == DONE);
  assign accept     = in_valid & in_ready;
  assign shift_en   = accept;
  assign shift_data = in_data;

  assign col_last = (col == CW'(IMG_WIDTH - 1));
  assign row_last = (row == RW'(IMG_HEIGHT - 1));
  assign col_in   = (col >= CW'(KERNEL - 1));
  assign row_in   = (row >= RW'(KERNEL - 1));
  // Phase counters hold (pos-(KERNEL-1)) mod STRIDE once inside the valid region.
  assign qualify  = col_in && row_in && (col_phase == '0) && (row_phase == '0);

  function automatic logic [PW-1:0] phase_next(input logic [PW-1:0] p);
    if (p == PW'(STRIDE - 1)) return '0;
    return p + PW'(1);
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      col_phase    <= '0;
      row_phase    <= '0;
      window_valid <= 1'b0;
      window_count <= '0;
    end else begin
      window_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= RUN;
            col          <= '0;
            row          <= '0;
            col_phase    <= '0;
            row_phase    <= '0;
            window_count <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            window_valid <= qualify;
            if (qualify && (window_count != 16'hFFFF))
              window_count <= window_count + 16'd1;
            if (col_last) begin
              col       <= '0;
              col_phase <= '0;
              row       <= row + RW'(1);
              if (row_in) row_phase <= phase_next(row_phase);
              if (row_last) state <= DONE;
            end else begin
              col <= col + CW'(1);
              if (col_in) col_phase <= phase_next(col_phase);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_convolver_window_ctrl.sv
// Randomized self-checking bench for convolver_window_ctrl; a default instance and a
// STRIDE=2 instance are checked against a row/col arithmetic window model.
module tb_convolver_window_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start1 = 1'b0, start2 = 1'b0;
  logic        valid1 = 1'b0, valid2 = 1'b0;
  logic [31:0] data1 = '0, data2 = '0;
  logic        ready1, ready2, sen1, sen2, wv1, wv2, busy1, busy2, done1, done2;
  logic [31:0] sdata1, sdata2;
  logic [15:0] cnt1, cnt2;
  logic        sel = 1'b0;

  int total = 0;
  int errors = 0;

  always #5 clock = ~clock;

  convolver_window_ctrl dut (
    .clock(clock), .reset(reset), .start(start1), .in_valid(valid1), .in_data(data1),
    .in_ready(ready1), .shift_en(sen1), .shift_data(sdata1), .window_valid(wv1),
    .window_count(cnt1), .busy(busy1), .done(done1)
  );

  convolver_window_ctrl #(.STRIDE(2)) dut_s2 (
    .clock(clock), .reset(reset), .start(start2), .in_valid(valid2), .in_data(data2),
    .in_ready(ready2), .shift_en(sen2), .shift_data(sdata2), .window_valid(wv2),
    .window_count(cnt2), .busy(busy2), .done(done2)
  );

  wire        o_ready = sel ? ready2 : ready1;
  wire        o_sen   = sel ? sen2   : sen1;
  wire [31:0] o_sdata = sel ? sdata2 : sdata1;
  wire        o_wv    = sel ? wv2    : wv1;
  wire [15:0] o_cnt   = sel ? cnt2   : cnt1;
  wire        o_busy  = sel ? busy2  : busy1;
  wire        o_done  = sel ? done2  : done1;

  // Window rule for an 8x8 frame with a 3x3 kernel, straight from pixel coordinates.
  function automatic bit qual(input int k, input int s);
    int r, c;
    r = k / 8;
    c = k % 8;
    return (r >= 2) && (c >= 2) && ((r - 2) % s == 0) && ((c - 2) % s == 0);
  endfunction

  task automatic drive(input logic st, input logic v, input logic [31:0] d);
    if (sel) begin start2 = st; valid2 = v; data2 = d; end
    else     begin start1 = st; valid1 = v; data1 = d; end
  endtask

  // Runs one frame from start, counting every cycle where the DUT departs from the model.
  task automatic run_frame(input bit s2, input int gap_pct, input bit pulse_starts,
                           input int abort_at, output int bad, output int pulses,
                           output int first_k, output int done_wv);
    int s, k, exp_cnt, cyc;
    bit exp_wv, exp_done, exp_run, finished, iv;
    logic [31:0] d;
    sel = s2;
    s = s2 ? 2 : 1;
    k = 0; exp_cnt = 0; cyc = 0;
    exp_wv = 0; exp_done = 0; exp_run = 1; finished = 0;
    bad = 0; pulses = 0; first_k = -1; done_wv = 0;
    drive(1'b1, 1'b0, '0);
    @(negedge clock);
    drive(1'b0, 1'b0, '0);
    while (cyc < 2000 && !finished) begin
      if (o_wv !== exp_wv) bad++;
      if (o_done !== exp_done) bad++;
      if (o_ready !== exp_run) bad++;
      if (o_busy !== exp_run) bad++;
      if (o_cnt !== 16'(exp_cnt)) bad++;
      if (o_wv === 1'b1) begin
        pulses++;
        if (first_k < 0) first_k = k - 1;
      end
      if (exp_done) begin
        done_wv = o_wv;
        drive(pulse_starts, 1'b1, '0);
        @(negedge clock);
        if (o_ready !== 1'b0 || o_done !== 1'b0 || o_wv !== 1'b0 || o_busy !== 1'b0) bad++;
        if (o_cnt !== 16'(exp_cnt)) bad++;
        finished = 1;
      end else if (abort_at >= 0 && k == abort_at) begin
        finished = 1;
      end else begin
        iv = ($urandom_range(99) >= gap_pct);
        d = (gap_pct == 0) ? 32'(k) : $urandom;
        drive(pulse_starts && k == 20, iv, d);
        #1;
        if (o_sen !== (iv & exp_run)) bad++;
        if (iv && o_sdata !== d) bad++;
        if (exp_run && iv) begin
          exp_wv = qual(k, s);
          if (exp_wv) exp_cnt++;
          k++;
          if (k == 64) begin exp_run = 0; exp_done = 1; end
        end else begin
          exp_wv = 0;
        end
        @(negedge clock);
        cyc++;
      end
    end
    if (!finished) bad++;
    drive(1'b0, 1'b0, '0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    valid1 = 1'b1;
    valid2 = 1'b1;
    repeat (2) @(negedge clock);
    total++;
    if (ready1 !== 1'b0 || sen1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_held: ready=%b shift_en=%b want 0/0", ready1, sen1);
    end
    reset = 1'b1;
    repeat (3) @(negedge clock);
    total++;
    if (ready1 !== 1'b0 || sen1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_ready: ready=%b shift_en=%b want 0/0", ready1, sen1);
    end
    total++;
    if (wv1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_flags: wv=%b busy=%b done=%b want 0", wv1, busy1, done1);
    end
    total++;
    if (cnt1 !== 16'd0 || cnt2 !== 16'd0) begin
      errors++;
      $display("[TB] FAIL idle_count: cnt=%0d/%0d want 0", cnt1, cnt2);
    end
    valid1 = 1'b0;
    valid2 = 1'b0;
  endtask

  task automatic test_full_frame();
    int bad, pulses, first_k, done_wv;
    run_frame(0, 0, 0, -1, bad, pulses, first_k, done_wv);
    total++;
    if (bad !== 0) begin errors++; $display("[TB] FAIL full_cycles: bad=%0d want 0", bad); end
    total++;
    if (pulses !== 36) begin errors++; $display("[TB] FAIL full_pulses: got %0d want 36", pulses); end
    total++;
    if (first_k !== 18) begin errors++; $display("[TB] FAIL full_first: got %0d want 18", first_k); end
    total++;
    if (done_wv !== 1) begin errors++; $display("[TB] FAIL full_done_wv: got %0d want 1", done_wv); end
    total++;
    if (cnt1 !== 16'd36) begin errors++; $display("[TB] FAIL full_count: got %0d want 36", cnt1); end
  endtask

  task automatic test_stride2();
    int bad, pulses, first_k, done_wv;
    run_frame(1, 0, 0, -1, bad, pulses, first_k, done_wv);
    total++;
    if (bad !== 0) begin errors++; $display("[TB] FAIL s2_cycles: bad=%0d want 0", bad); end
    total++;
    if (pulses !== 9) begin errors++; $display("[TB] FAIL s2_pulses: got %0d want 9", pulses); end
    total++;
    if (first_k !== 18) begin errors++; $display("[TB] FAIL s2_first: got %0d want 18", first_k); end
    total++;
    if (cnt2 !== 16'd9) begin errors++; $display("[TB] FAIL s2_count: got %0d want 9", cnt2); end
  endtask

  task automatic test_gaps();
    int bad, pulses, first_k, done_wv;
    run_frame(0, 50, 0, -1, bad, pulses, first_k, done_wv);
    total++;
    if (bad !== 0) begin errors++; $display("[TB] FAIL gap_cycles: bad=%0d want 0", bad); end
    total++;
    if (pulses !== 36) begin errors++; $display("[TB] FAIL gap_pulses: got %0d want 36", pulses); end
    total++;
    if (cnt1 !== 16'd36) begin errors++; $display("[TB] FAIL gap_count: got %0d want 36", cnt1); end
  endtask

  task automatic test_ignored_start();
    int bad, pulses, first_k, done_wv;
    run_frame(0, 30, 1, -1, bad, pulses, first_k, done_wv);
    total++;
    if (bad !== 0) begin errors++; $display("[TB] FAIL istart_cycles: bad=%0d want 0", bad); end
    total++;
    if (cnt1 !== 16'd36) begin errors++; $display("[TB] FAIL istart_count: got %0d want 36", cnt1); end
  endtask

  task automatic test_back_to_back();
    int bad, pulses, first_k, done_wv;
    for (int f = 0; f < 2; f++) begin
      run_frame(0, 0, 0, -1, bad, pulses, first_k, done_wv);
      total++;
      if (bad !== 0 || pulses !== 36) begin
        errors++;
        $display("[TB] FAIL b2b_frame%0d: bad=%0d pulses=%0d want 0/36", f, bad, pulses);
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad, pulses, first_k, done_wv, exp_cnt;
    exp_cnt = 0;
    for (int k = 0; k <= 30; k++) if (qual(k, 1)) exp_cnt++;
    run_frame(0, 0, 0, 31, bad, pulses, first_k, done_wv);
    total++;
    if (bad !== 0 || cnt1 !== 16'(exp_cnt)) begin
      errors++;
      $display("[TB] FAIL midrst_pre: bad=%0d cnt=%0d want 0/%0d", bad, cnt1, exp_cnt);
    end
    valid1 = 1'b1;
    reset = 1'b0;
    #1;
    total++;
    if (ready1 !== 1'b0 || sen1 !== 1'b0 || wv1 !== 1'b0 || busy1 !== 1'b0 ||
        done1 !== 1'b0 || cnt1 !== 16'd0) begin
      errors++;
      $display("[TB] FAIL midrst_clear: rdy=%b sen=%b wv=%b busy=%b done=%b cnt=%0d want all 0",
               ready1, sen1, wv1, busy1, done1, cnt1);
    end
    @(negedge clock);
    valid1 = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    run_frame(0, 0, 0, -1, bad, pulses, first_k, done_wv);
    total++;
    if (bad !== 0 || pulses !== 36 || cnt1 !== 16'd36) begin
      errors++;
      $display("[TB] FAIL midrst_frame: bad=%0d pulses=%0d cnt=%0d want 0/36/36", bad, pulses, cnt1);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_stride2();
    test_gaps();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, errors);
    $finish;
  end

endmodule

// File: doc/convolver_window_ctrl.md
# convolver_window_ctrl

Sequencing controller for the convolver's input shift-register chain. It accepts a raster-order pixel stream through a valid/ready handshake and drives the shift enable and shift data of the chain. It tracks row and column position and flags each cycle on which the chain holds a complete, in-bounds KERNEL×KERNEL window at the configured stride. The multiply-accumulate stage consumes the chain's data_out only on flagged cycles.

## Interface
- IMG_WIDTH, 8, pixels per row (≥ KERNEL)
- IMG_HEIGHT, 8, rows per frame (≥ KERNEL)
- KERNEL, 3, window edge length
- STRIDE, 1, window step in both dimensions (≥ 1)
- DATA_WIDTH, 32, pixel width
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- start  in  1  one-cycle request to begin a frame
- in_valid  in  1  upstream pixel present
- in_data  in  DATA_WIDTH  upstream pixel
- in_ready  out  1  controller accepts a pixel this cycle
- shift_en  out  1  shift-register advance strobe
- shift_data  out  DATA_WIDTH  value shifted into the chain
- window_valid  out  1  chain holds a valid window this cycle
- window_count  out  16  windows flagged since the last start
- busy  out  1  frame in progress
- done  out  1  one-cycle frame-complete pulse

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 → RUN. On that edge, clear row, col, the stride phase counters and window_count.
- RUN:
  - in_ready=1, busy=1.
  - accept = in_valid & in_ready.
  - shift_en = accept, combinational. shift_data = in_data, combinational pass-through.
  - When accept=0, counters hold and no shift occurs.
- Position update on each accept:
  - col increments.
  - At col=IMG_WIDTH-1, col wraps to 0 and row increments.
- Window test applies to the pixel being accepted, at (row,col). The pixel qualifies when all of these hold:
  - row ≥ KERNEL-1
  - col ≥ KERNEL-1
  - (row-(KERNEL-1)) mod STRIDE = 0
  - (col-(KERNEL-1)) mod STRIDE = 0
- Stride counting:
  - Implemented with row/col phase counters, not a divider.
  - The col phase resets at each row wrap.
  - The row phase advances only once row ≥ KERNEL-1.
- On the accept of a qualifying pixel:
  - window_valid is registered to 1 for the following cycle.
  - window_count increments on that same edge.
- Last pixel (row=IMG_HEIGHT-1, col=IMG_WIDTH-1) accepted → DONE.
- DONE: in_ready=0, busy=0, done=1, for exactly one cycle. Then → IDLE.
- start in RUN or DONE is ignored.
- window_count holds after done until the next start.
- Expected windows per frame: ((IMG_HEIGHT-KERNEL)/STRIDE+1)·((IMG_WIDTH-KERNEL)/STRIDE+1), integer division.
- window_count saturates at 16'hFFFF.

## Timing
- Reset values: state=IDLE, in_ready=0, window_valid=0, window_count=0, busy=0, done=0.
  - shift_en=0 follows combinationally, because in_ready=0.
- Reset asserted mid-frame: all of the above apply immediately. The partially filled chain is not cleared by this block.
- start → in_ready=1 on the next cycle. The earliest accept is one cycle after start.
- The chain captures shift_data on the same edge that the controller counts the accept.
- window_valid is high in the cycle after the qualifying accept edge. In that cycle the chain's data_out already contains the window.
- Back-to-back accepts produce window_valid on consecutive cycles where qualifying.
- Stalls (in_valid=0) insert window_valid=0 cycles and never drop or duplicate windows.
- The last pixel's accept edge sets state=DONE. If that pixel qualifies, window_valid=1 and done=1 in the same cycle.
- The next start can be accepted in the cycle after done.

## Test plan
- Reset/idle: hold reset=0, then release with in_valid=1 and no start. Required: in_ready=0, shift_en=0, all outputs 0, no counting.
- Full frame, defaults (8×8, K=3, S=1), continuous in_valid, pixel k = k:
  - first window_valid in the cycle after pixel 18 is accepted;
  - exactly 36 window_valid cycles;
  - window_valid low after cols 0–1 of each row;
  - done one cycle after the pixel-63 accept edge, coincident with the final window_valid;
  - window_count=36.
- STRIDE=2, 8×8, K=3:
  - windows only at (row,col) ∈ {2,4,6}×{2,4,6};
  - 9 window_valid pulses; window_count=9.
- Random in_valid gaps (~50% duty), defaults:
  - shift_en high only when in_valid & in_ready;
  - still exactly 36 windows, at the same pixel indices as the gap-free run.
- Ignored start: pulse start mid-frame and during DONE. Required: counters unaffected, no restart, window_count=36 at done.
- Reset mid-operation: assert reset after pixel 30, then start a fresh frame. Required: outputs 0 immediately; the new frame yields 36 windows and window_count=36.
